uart_rx: RTL and testbench

//   UART receiver; the receive-side counterpart of uart_tx on the same serial link.

---
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, LSB-first frames with 2-flop input sync.
// Define UART_RX_PARITY_EN to receive and check an even parity bit.
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_END = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_n;

  logic rx_meta;
  logic rx_s;

  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] clk_cnt_n;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_cnt_n;

  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_n;
  logic [DATA_BITS-1:0] data_n;

  logic valid_n;
  logic ferr_n;
  logic perr_n;
  logic half_done;
  logic bit_done;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bit_n;
`endif

  assign half_done = (clk_cnt == HALF_END);
  assign bit_done  = (clk_cnt == BIT_END);
  assign busy      = (state != IDLE);

  // rx is asynchronous; only rx_s is ever looked at
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      clk_cnt    <= clk_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      data_out   <= data_n;
      data_valid <= valid_n;
      frame_err  <= ferr_n;
      parity_err <= perr_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_bit <= 1'b0;
    end else begin
      par_bit <= par_bit_n;
    end
  end
`endif

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt + CW'(1);
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    data_n    = data_out;
    valid_n   = 1'b0;
    ferr_n    = frame_err;
    perr_n    = parity_err;
`ifdef UART_RX_PARITY_EN
    par_bit_n = par_bit;
`endif

    unique case (state)
      IDLE: begin
        clk_cnt_n = '0;
        if (!rx_s) begin
          state_n   = START;
          bit_cnt_n = '0;
        end
      end

      // a start bit that is high again at its middle is a glitch
      START: begin
        if (half_done) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (bit_done) begin
          clk_cnt_n = '0;
          shift_n   = {rx_s, shift[DATA_BITS-1:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n   = PARITY;
`else
            state_n   = STOP;
`endif
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          clk_cnt_n = '0;
          par_bit_n = rx_s;
          state_n   = STOP;
        end
      end
`endif

      // leaving at mid-stop lets an immediately following start be caught
      STOP: begin
        if (bit_done) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          data_n    = shift;
          ferr_n    = ~rx_s;
          valid_n   = 1'b1;
          state_n   = IDLE;
`ifdef UART_RX_PARITY_EN
          perr_n    = ^{shift, par_bit};
`else
          perr_n    = 1'b0;
`endif
        end
      end

      default: begin
        clk_cnt_n = '0;
        bit_cnt_n = '0;
        state_n   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames against a sample-point line model.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

  localparam int DB   = 8;
  localparam int OS   = 16;
  localparam int HALF = OS / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NF   = DB + 2;
`else
  localparam int NF   = DB + 1;
`endif
  localparam int LAT  = 2 + HALF + NF * OS;
  localparam int NL   = 32768;

  logic          clk   = 1'b0;
  logic          n_rst = 1'b0;
  logic          rx    = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  uart_rx #(
    .DATA_BITS   (DB),
    .OVERSAMPLING(OS)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc     = 0;
  int nchecks = 0;
  int nerr    = 0;
  int nvalid  = 0;
  bit line[NL];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // line[c] is the rx level driven just after clock edge c
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (cyc < NL) line[cyc] = rx;
  end

  typedef struct {
    logic [DB-1:0] d;
    bit            fe;
    bit            pe;
    int            f;
  } exp_t;

  exp_t q[$];

  // frame model: find a low level, test its middle, read every mid-bit point
  int p = 1;
  int f = 0;
  bit m_in = 0;
  bit m_ok = 0;

  always @(negedge clk) begin : model
    bit   prog;
    int   s;
    exp_t e;
    if (!n_rst) begin
      q.delete();
      m_in = 0;
      p    = cyc + 1;
    end else begin
      prog = 1;
      while (prog) begin
        prog = 0;
        if (!m_in) begin
          while (p <= cyc && line[p]) p++;
          if (p <= cyc) begin
            f    = p;
            m_in = 1;
            m_ok = 0;
            prog = 1;
          end
        end else if (!m_ok) begin
          if (f + HALF <= cyc) begin
            if (line[f+HALF]) begin
              m_in = 0;
              p    = f + HALF + 1;
            end else begin
              m_ok = 1;
            end
            prog = 1;
          end
        end else begin
          s = f + HALF + NF * OS;
          if (s <= cyc) begin
            for (int i = 0; i < DB; i++)
              e.d[i] = line[f+HALF+(i+1)*OS];
            e.fe = !line[s];
`ifdef UART_RX_PARITY_EN
            e.pe = (^e.d) ^ line[f+HALF+(DB+1)*OS];
`else
            e.pe = 1'b0;
`endif
            e.f  = f;
            q.push_back(e);
            m_in = 0;
            p    = s + 1;
            prog = 1;
          end
        end
      end
    end
  end

  logic [DB-1:0] hd = '0;
  bit            hf = 0;
  bit            hp = 0;

  always @(negedge clk) begin : compare
    exp_t e;
    int   lat;
    if (!n_rst) begin
      hd = '0;
      hf = 0;
      hp = 0;
    end
    if (data_valid) begin
      nvalid++;
      if (q.size() == 0) begin
        chk("valid_spurious", 32'(data_valid), 32'd0);
      end else begin
        e   = q.pop_front();
        lat = cyc - e.f;
        nchecks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
          nerr++;
          $display("FAIL latency: got %0d expected %0d+/-1", lat, LAT);
        end
        hd = e.d;
        hf = e.fe;
        hp = e.pe;
      end
    end else if (q.size() != 0 && cyc > q[0].f + LAT + 1) begin
      chk("valid_missing", 32'(data_valid), 32'd1);
      q.delete(0);
    end
    chk("data_out", 32'(data_out), 32'(hd));
    chk("frame_err", 32'(frame_err), 32'(hf));
    chk("parity_err", 32'(parity_err), 32'(hp));
  end

  task automatic drive(bit v, int n);
    repeat (n) begin
      @(posedge clk);
      #1 rx = v;
    end
  endtask

  task automatic send(logic [DB-1:0] d, bit stopv, bit pb, int nstop);
    drive(1'b0, OS);
    for (int i = 0; i < DB; i++) drive(d[i], OS);
`ifdef UART_RX_PARITY_EN
    drive(pb, OS);
`else
    if (pb === 1'bx) drive(1'b1, 1);
`endif
    drive(stopv, OS);
    if (nstop > 1) drive(1'b1, OS * (nstop - 1));
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
  endtask

  initial begin
    #3_000_000;
    nerr++;
    $display("FAIL watchdog: finished=0 expected=1");
    summary();
    $finish;
  end

  initial begin
    int            nv;
    logic [DB-1:0] d;
    logic [DB-1:0] v81;
    bit            stopv;
    bit            pb;

    for (int i = 0; i < NL; i++) line[i] = 1'b1;
    v81 = 8'h81;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    n_rst = 1'b1;
    drive(1'b1, 10);

    nv = nvalid;
    send(8'hA5, 1'b1, 1'b0, 1);
    drive(1'b1, 20);
    chk("a5_data", 32'(data_out), 32'h A5);
    chk("a5_frame_err", 32'(frame_err), 32'd0);
    chk("a5_busy", 32'(busy), 32'd0);
    chk("a5_pulses", 32'(nvalid - nv), 32'd1);

    nv = nvalid;
    drive(1'b0, 4);
    drive(1'b1, 2);
    chk("glitch_busy_high", 32'(busy), 32'd1);
    drive(1'b1, 7);
    chk("glitch_busy_low", 32'(busy), 32'd0);
    drive(1'b1, 200);
    chk("glitch_no_pulse", 32'(nvalid - nv), 32'd0);

    send(8'h3C, 1'b0, 1'b0, 1);
    drive(1'b1, 30);
    chk("bad_stop_data", 32'(data_out), 32'h3C);
    chk("bad_stop_frame_err", 32'(frame_err), 32'd1);

    nv = nvalid;
    send(8'h00, 1'b1, 1'b0, 1);
    send(8'hFF, 1'b1, 1'b0, 1);
    send(8'h55, 1'b1, 1'b0, 1);
    drive(1'b1, 30);
    chk("b2b_pulses", 32'(nvalid - nv), 32'd3);
    chk("b2b_last_data", 32'(data_out), 32'h55);
    chk("b2b_frame_err", 32'(frame_err), 32'd0);

    drive(1'b0, OS);
    for (int i = 0; i < 4; i++) drive(v81[i], OS);
    drive(v81[4], HALF);
    @(posedge clk);
    #3 n_rst = 1'b0;
    rx = 1'b1;
    #1;
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_valid", 32'(data_valid), 32'd0);
    chk("midrst_frame_err", 32'(frame_err), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    nv = nvalid;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    drive(1'b1, 20);
    send(8'h7E, 1'b1, 1'b0, 1);
    drive(1'b1, 30);
    chk("after_rst_data", 32'(data_out), 32'h7E);
    chk("after_rst_frame_err", 32'(frame_err), 32'd0);
    chk("after_rst_pulses", 32'(nvalid - nv), 32'd1);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1, 1);
    drive(1'b1, 20);
    chk("par_ok_data", 32'(data_out), 32'h07);
    chk("par_ok_err", 32'(parity_err), 32'd0);
    send(8'h07, 1'b1, 1'b0, 1);
    drive(1'b1, 20);
    chk("par_bad_data", 32'(data_out), 32'h07);
    chk("par_bad_err", 32'(parity_err), 32'd1);
`endif

    nv = nvalid;
    drive(1'b0, 170);
    chk("break_data", 32'(data_out), 32'd0);
    chk("break_frame_err", 32'(frame_err), 32'd1);
    chk("break_pulses", 32'(nvalid - nv), 32'd1);
    drive(1'b0, 30);
    drive(1'b1, 400);
    chk("break_recovered_busy", 32'(busy), 32'd0);

    for (int k = 0; k < 40; k++) begin
      d     = DB'($urandom);
      stopv = ($urandom_range(0, 7) != 0);
      pb    = (^d) ^ ($urandom_range(0, 5) == 0);
      send(d, stopv, pb, int'($urandom_range(1, 2)));
      drive(1'b1, int'($urandom_range(0, 24)));
      if ($urandom_range(0, 4) == 0) begin
        drive(1'b0, int'($urandom_range(1, 6)));
        drive(1'b1, 30);
      end
    end

    drive(1'b1, 400);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    summary();
    $finish;
  end

endmodule
